// File: rtl/keypad_matrix_emulator_if.sv
// Key-press command channel for the keypad matrix emulator: valid/ready handshake
// carrying a key code and a hold length in scan hits.
interface keypad_matrix_emulator_if #(
  parameter int HOLD_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Column-side responder for a 4x4 row-scanned keypad: replays queued key presses by
// pulling the matching active-low column low whenever the key's row is strobed.
module keypad_matrix_emulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 8,
  parameter int GAP_SCANS  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  keypad_matrix_emulator_if.slave  cmd,
  input  logic [3:0]               keypad_row_i,
  output logic [3:0]               keypad_col_o,
  output logic                     pressed_o,
  output logic [3:0]               cur_key_o,
  output logic                     busy_o
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] GAP_LAST = HOLD_W'(GAP_SCANS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  function automatic logic [3:0] key_row(input logic [3:0] k);
    unique case (k)
      4'h7, 4'h4, 4'h1, 4'h0: key_row = 4'b1110;
      4'h8, 4'h5, 4'h2, 4'hA: key_row = 4'b1101;
      4'h9, 4'h6, 4'h3, 4'hB: key_row = 4'b1011;
      default:                key_row = 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] key_col(input logic [3:0] k);
    unique case (k)
      4'h7, 4'h8, 4'h9, 4'hC: key_col = 4'b1110;
      4'h4, 4'h5, 4'h6, 4'hD: key_col = 4'b1101;
      4'h1, 4'h2, 4'h3, 4'hE: key_col = 4'b1011;
      default:                key_col = 4'b0111;
    endcase
  endfunction

  logic [HOLD_W+3:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  state_t            state_q, state_d;
  logic [3:0]        cur_key_q, cur_key_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [3:0]        row_q;
  logic [3:0]        col_q, col_d;
  logic              push, pop, hit;
  logic [3:0]        krow;
  logic [3:0]        head_key;
  logic [HOLD_W-1:0] head_hold;

  assign cmd.cmd_ready = (cnt_q != FULL_CNT);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign {head_key, head_hold} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd.cmd_key, cmd.cmd_hold};
  end

  always_comb begin
    state_d   = state_q;
    cur_key_d = cur_key_q;
    hold_d    = hold_q;
    hit_cnt_d = hit_cnt_q;
    pop       = 1'b0;
    krow      = key_row(cur_key_q);
    // A hit is the first cycle of a strobe on the current key's row.
    hit       = (keypad_row_i == krow) && (row_q != krow);
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop       = 1'b1;
          cur_key_d = head_key;
          hold_d    = (head_hold == '0) ? HOLD_W'(1) : head_hold;
          hit_cnt_d = '0;
          state_d   = S_PRESS;
        end
      end
      S_PRESS: begin
        if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        // Release only once the row has moved on, so a strobe is never cut short.
        if (hit_cnt_q == hold_q && keypad_row_i != krow) begin
          state_d   = S_GAP;
          hit_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (hit) begin
          if (hit_cnt_q >= GAP_LAST) begin
            state_d   = S_IDLE;
            cur_key_d = 4'h0;
            hold_d    = '0;
            hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    col_d = (state_q == S_PRESS && keypad_row_i == krow) ? key_col(cur_key_q) : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      cur_key_q <= 4'h0;
      hold_q    <= '0;
      hit_cnt_q <= '0;
      row_q     <= 4'b1111;
      col_q     <= 4'b1111;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      state_q   <= state_d;
      cur_key_q <= cur_key_d;
      hold_q    <= hold_d;
      hit_cnt_q <= hit_cnt_d;
      row_q     <= keypad_row_i;
      col_q     <= col_d;
    end
  end

  assign keypad_col_o = col_q;
  assign pressed_o    = (state_q == S_PRESS);
  assign cur_key_o    = cur_key_q;
  assign busy_o       = (state_q != S_IDLE) || (cnt_q != '0);

endmodule
